// File: rtl/line_memory.sv
// Line-granular backing memory for the L1 data cache refill/write-back port.
// Serves one 256-bit line request at a time with a fixed latency and a single-cycle ack.
module line_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  req_count_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_COOL
    } state_t;

    state_t              r_state;
    logic [LAT_W-1:0]    r_cnt;
    logic                r_write;
    logic [26:0]         r_line;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_mem [DEPTH];

    logic                w_in_range;
    logic                w_done;
    logic [IDX_W-1:0]    w_idx;
    logic                w_unused_lo;

    assign w_in_range  = ({5'd0, r_line} < DEPTH);
    assign w_idx       = r_line[IDX_W-1:0];
    assign w_unused_lo = ^addr_i[4:0];

    // Counter is loaded with LATENCY-1 and the ACK transition fires when it reads
    // zero, so ACK is entered exactly LATENCY edges after acceptance (LATENCY=1
    // spends its single busy cycle here before the ack cycle).
    assign w_done = (r_state == S_WAIT) && (r_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_line      <= '0;
            r_wdata     <= '0;
            ack_o       <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            data_o      <= '0;
            req_count_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_line      <= addr_i[31:5];
                        r_write     <= write_i;
                        r_wdata     <= data_i;
                        r_cnt       <= LAT_W'(LATENCY - 1);
                        req_count_o <= req_count_o + 1'b1;
                        busy_o      <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_ACK;
                        ack_o   <= 1'b1;
                        if (!r_write) begin
                            data_o <= w_in_range ? r_mem[w_idx] : '0;
                        end
                        if (!w_in_range) begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                S_ACK: begin
                    ack_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    r_state <= S_COOL;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so its contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_done && r_write && w_in_range) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_line_memory.sv
// Randomized self-checking bench for line_memory: a LATENCY=10 build and a
// LATENCY=1 build with a narrow request counter to exercise counter wrap.
module tb_line_memory;

    localparam int unsigned LAT   = 10;
    localparam int unsigned DEP   = 512;
    localparam int unsigned LW    = 256;
    localparam int unsigned LAT_B = 1;
    localparam int unsigned DEP_B = 16;
    localparam int unsigned CW_B  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           en, wr;
    logic [31:0]    addr;
    logic [LW-1:0]  din;
    logic           ack, busy, err;
    logic [LW-1:0]  dout;
    logic [15:0]    cnt;

    logic           en_b, wr_b;
    logic [31:0]    addr_b;
    logic [LW-1:0]  din_b;
    logic           ack_b, busy_b, err_b;
    logic [LW-1:0]  dout_b;
    logic [CW_B-1:0] cnt_b;

    line_memory #(.LATENCY(LAT), .DEPTH(DEP), .LINE_W(LW), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
        .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy), .err_o(err),
        .req_count_o(cnt)
    );

    line_memory #(.LATENCY(LAT_B), .DEPTH(DEP_B), .LINE_W(LW), .CNT_W(CW_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .write_i(wr_b), .addr_i(addr_b),
        .data_i(din_b), .ack_o(ack_b), .data_o(dout_b), .busy_o(busy_b), .err_o(err_b),
        .req_count_o(cnt_b)
    );

    int tests = 0;
    int fails = 0;

    logic [LW-1:0] mdl [int unsigned];
    int unsigned   exp_cnt;
    bit            exp_err;
    int unsigned   exp_cnt_b;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference behaviour: one request = one count, out-of-range lines read as
    // zero and never store, and err is sticky once any out-of-range line is touched.
    task automatic mdl_apply(input bit w, input logic [31:0] a, input logic [LW-1:0] d,
                             output logic [LW-1:0] exp_rd, output bit known);
        int unsigned line;
        line    = a >> 5;
        exp_cnt = (exp_cnt + 1) % 65536;
        exp_rd  = '0;
        known   = 1'b0;
        if (line >= DEP) begin
            exp_err = 1'b1;
            known   = 1'b1;
        end else if (w) begin
            mdl[line] = d;
        end else if (mdl.exists(line)) begin
            exp_rd = mdl[line];
            known  = 1'b1;
        end
    endtask

    task automatic req_a(input bit w, input logic [31:0] a, input logic [LW-1:0] d,
                         output int lat, output logic [LW-1:0] rd, output logic ack_w2);
        logic [15:0] old;
        bit acc;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; din = d;
        old = cnt; acc = 1'b0; lat = -1; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnt !== old) begin acc = 1'b1; break; end
        end
        if (acc) begin
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk);
                if (ack === 1'b1) begin lat = i; rd = dout; break; end
            end
        end
        en = 1'b0;
        @(negedge clk);
        ack_w2 = ack;
    endtask

    task automatic req_b(input bit w, input logic [31:0] a, input logic [LW-1:0] d,
                         output int lat, output logic [LW-1:0] rd, output logic ack_w2);
        logic [CW_B-1:0] old;
        bit acc;
        @(negedge clk);
        en_b = 1'b1; wr_b = w; addr_b = a; din_b = d;
        old = cnt_b; acc = 1'b0; lat = -1; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnt_b !== old) begin acc = 1'b1; break; end
        end
        if (acc) begin
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk);
                if (ack_b === 1'b1) begin lat = i; rd = dout_b; break; end
            end
        end
        en_b = 1'b0;
        @(negedge clk);
        ack_w2 = ack_b;
    endtask

    task automatic test_reset();
        logic [LW-1:0] d, e;
        bit k;
        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
        repeat (3) @(negedge clk);
        tests++; if (ack !== 1'b0)  begin fails++; $display("FAIL reset_ack got=%b exp=0", ack); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (err !== 1'b0)  begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
        tests++; if (dout !== '0)   begin fails++; $display("FAIL reset_data got=%h exp=0", dout); end
        tests++; if (cnt !== 16'h0) begin fails++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
        tests++; if (cnt_b !== '0)  begin fails++; $display("FAIL reset_cnt_b got=%h exp=0", cnt_b); end
        exp_cnt = 0; exp_err = 1'b0; exp_cnt_b = 0;
        d = rand_line();
        en = 1'b1; wr = 1'b1; addr = 32'h20; din = d;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (cnt !== 16'h1) begin fails++; $display("FAIL reset_first_accept cnt got=%h exp=1", cnt); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack === 1'b1) break;
        end
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL reset_first_ack got=%b exp=1", ack); end
        en = 1'b0;
        mdl_apply(1'b1, 32'h20, d, e, k);
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [LW-1:0] d, e, rd;
        logic w2;
        int lat;
        bit k;
        d = {8{32'hDEADBEEF}};
        req_a(1'b1, 32'h0000_0400, d, lat, rd, w2);
        mdl_apply(1'b1, 32'h0000_0400, d, e, k);
        tests++; if (lat != LAT) begin fails++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
        tests++; if (w2 !== 1'b0) begin fails++; $display("FAIL wr_ack_width got=%b exp=0", w2); end
        req_a(1'b0, 32'h0000_0400, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'h0000_0400, '0, e, k);
        tests++; if (lat != LAT) begin fails++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
        tests++; if (rd !== e) begin fails++; $display("FAIL rd_data got=%h exp=%h", rd, e); end
        tests++; if (cnt !== exp_cnt[15:0]) begin fails++; $display("FAIL rd_count got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_low_bits();
        logic [LW-1:0] d, e, rd;
        logic w2;
        int lat;
        bit k;
        d = rand_line();
        req_a(1'b1, 32'h40, d, lat, rd, w2);
        mdl_apply(1'b1, 32'h40, d, e, k);
        req_a(1'b0, 32'h5F, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'h5F, '0, e, k);
        tests++; if (rd !== e) begin fails++; $display("FAIL low_bits got=%h exp=%h", rd, e); end
    endtask

    task automatic test_oor();
        logic [LW-1:0] d, e, rd;
        logic w2;
        int lat;
        bit k;
        d = rand_line();
        req_a(1'b1, 32'h0, d, lat, rd, w2);
        mdl_apply(1'b1, 32'h0, d, e, k);
        req_a(1'b0, 32'h0000_4000, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'h0000_4000, '0, e, k);
        tests++; if (lat != LAT) begin fails++; $display("FAIL oor_latency got=%0d exp=%0d", lat, LAT); end
        tests++; if (rd !== e) begin fails++; $display("FAIL oor_read_data got=%h exp=%h", rd, e); end
        tests++; if (err !== exp_err) begin fails++; $display("FAIL oor_err got=%b exp=%b", err, exp_err); end
        d = rand_line();
        req_a(1'b1, 32'h0000_4000, d, lat, rd, w2);
        mdl_apply(1'b1, 32'h0000_4000, d, e, k);
        req_a(1'b0, 32'h0, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'h0, '0, e, k);
        tests++; if (rd !== e) begin fails++; $display("FAIL oor_line0_intact got=%h exp=%h", rd, e); end
        tests++; if (err !== exp_err) begin fails++; $display("FAIL oor_err_sticky got=%b exp=%b", err, exp_err); end
    endtask

    task automatic test_random();
        logic [LW-1:0] d, e, rd;
        logic [31:0] a;
        logic w2;
        int lat;
        bit k, w;
        for (int n = 0; n < 30; n++) begin
            w = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) a = ((DEP + $urandom_range(0, 3)) << 5);
            else a = ($urandom_range(0, 31) << 5);
            a[4:0] = 5'($urandom);
            d = rand_line();
            req_a(w, a, d, lat, rd, w2);
            mdl_apply(w, a, d, e, k);
            tests++; if (lat != LAT) begin fails++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, LAT); end
            if (!w && k) begin
                tests++; if (rd !== e) begin fails++; $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, a, rd, e); end
            end
            tests++; if (err !== exp_err) begin fails++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, exp_err); end
            tests++; if (cnt !== exp_cnt[15:0]) begin fails++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, cnt, exp_cnt); end
        end
    endtask

    task automatic test_held_enable();
        logic [LW-1:0] x, y, e, rd;
        logic [15:0] prev;
        logic w2;
        int acc_idx [4];
        int ack_idx [4];
        int nacc, nack, lat;
        bit k;
        x = rand_line(); y = rand_line();
        nacc = 0; nack = 0;
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'd5 << 5; din = x;
        prev = cnt;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cnt !== prev) begin
                if (nacc < 4) acc_idx[nacc] = i;
                nacc++;
                prev = cnt;
                addr = 32'd6 << 5; din = y;
            end
            if (ack === 1'b1) begin
                if (nack < 4) ack_idx[nack] = i;
                nack++;
                if (nack == 2) en = 1'b0;
            end
        end
        en = 1'b0;
        tests++; if (nacc != 2) begin fails++; $display("FAIL held_accepts got=%0d exp=2", nacc); end
        tests++; if (nack != 2) begin fails++; $display("FAIL held_acks got=%0d exp=2", nack); end
        if (nacc >= 2 && nack >= 2) begin
            tests++; if (ack_idx[0] - acc_idx[0] != LAT) begin fails++; $display("FAIL held_lat0 got=%0d exp=%0d", ack_idx[0] - acc_idx[0], LAT); end
            tests++; if (acc_idx[1] - ack_idx[0] != 3) begin fails++; $display("FAIL back_to_back got=%0d exp=3", acc_idx[1] - ack_idx[0]); end
            tests++; if (ack_idx[1] - acc_idx[1] != LAT) begin fails++; $display("FAIL held_lat1 got=%0d exp=%0d", ack_idx[1] - acc_idx[1], LAT); end
        end
        mdl_apply(1'b1, 32'd5 << 5, x, e, k);
        mdl_apply(1'b1, 32'd6 << 5, y, e, k);
        req_a(1'b0, 32'd5 << 5, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'd5 << 5, '0, e, k);
        tests++; if (rd !== e) begin fails++; $display("FAIL wait_addr_change line5 got=%h exp=%h", rd, e); end
        req_a(1'b0, 32'd6 << 5, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'd6 << 5, '0, e, k);
        tests++; if (rd !== e) begin fails++; $display("FAIL wait_addr_change line6 got=%h exp=%h", rd, e); end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] old_d, new_d, e, rd;
        logic [15:0] prev;
        logic w2;
        int lat, acks;
        bit k, acc;
        old_d = rand_line(); new_d = rand_line();
        req_a(1'b1, 32'h80, old_d, lat, rd, w2);
        mdl_apply(1'b1, 32'h80, old_d, e, k);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h80; din = new_d;
        prev = cnt; acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cnt !== prev) begin acc = 1'b1; break; end
        end
        tests++; if (!acc) begin fails++; $display("FAIL rstmid_accept got=0 exp=1"); end
        repeat (4) @(negedge clk);
        rst = 1'b1; en = 1'b0;
        #1;
        tests++; if ({ack, busy, err} !== 3'b000) begin fails++; $display("FAIL rstmid_flags got=%b exp=000", {ack, busy, err}); end
        tests++; if (dout !== '0 || cnt !== 16'h0) begin fails++; $display("FAIL rstmid_data_cnt got=%h/%h exp=0/0", dout, cnt); end
        exp_cnt = 0; exp_err = 1'b0; exp_cnt_b = 0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
        req_a(1'b0, 32'h80, '0, lat, rd, w2);
        mdl_apply(1'b0, 32'h80, '0, e, k);
        tests++; if (rd !== e) begin fails++; $display("FAIL rstmid_retain got=%h exp=%h", rd, e); end
        tests++; if (lat != LAT) begin fails++; $display("FAIL rstmid_next_latency got=%0d exp=%0d", lat, LAT); end
        tests++; if (cnt !== exp_cnt[15:0]) begin fails++; $display("FAIL rstmid_count got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_lat1();
        logic [LW-1:0] d, rd;
        logic w2;
        int lat;
        d = rand_line();
        req_b(1'b1, 32'd3 << 5, d, lat, rd, w2);
        exp_cnt_b = (exp_cnt_b + 1) % (1 << CW_B);
        tests++; if (lat != LAT_B) begin fails++; $display("FAIL lat1_wr_latency got=%0d exp=%0d", lat, LAT_B); end
        tests++; if (w2 !== 1'b0) begin fails++; $display("FAIL lat1_ack_width got=%b exp=0", w2); end
        while (exp_cnt_b != (1 << CW_B) - 1) begin
            req_b(1'b0, 32'd3 << 5, '0, lat, rd, w2);
            exp_cnt_b = (exp_cnt_b + 1) % (1 << CW_B);
            tests++; if (lat != LAT_B || rd !== d) begin
                fails++; $display("FAIL lat1_read n=%0d lat=%0d exp=%0d data=%h exp=%h", exp_cnt_b, lat, LAT_B, rd, d);
            end
        end
        tests++; if (cnt_b !== CW_B'(exp_cnt_b)) begin fails++; $display("FAIL lat1_count_max got=%h exp=%h", cnt_b, exp_cnt_b); end
        req_b(1'b0, 32'd3 << 5, '0, lat, rd, w2);
        exp_cnt_b = (exp_cnt_b + 1) % (1 << CW_B);
        tests++; if (cnt_b !== CW_B'(exp_cnt_b)) begin fails++; $display("FAIL lat1_count_wrap got=%h exp=%h", cnt_b, exp_cnt_b); end
        tests++; if (lat != LAT_B) begin fails++; $display("FAIL lat1_wrap_latency got=%0d exp=%0d", lat, LAT_B); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_low_bits();
        test_oor();
        test_random();
        test_held_enable();
        test_reset_mid();
        test_lat1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
